div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Parametrised multi-cycle restoring divider for the execute stage, serving DIV/DIVU.
- Driven by execute, which holds execute_pause high until ready; the result goes to HI (remainder) and LO (quotient) through the normal HILO path.
- Successor to the single-cycle arithmetic in execute: width is generic, signed and unsigned modes are selectable, and an annul input cancels a division in flight (flush/branch).

Parameters:
- WIDTH, 32, operand width in bits; quotient and remainder are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request a division; must stay high until ready is seen.
- annul  input  1  cancel current or pending division.
- signed_div  input  1  1 = two's-complement operands, 0 = unsigned.
- opdata1  input  WIDTH  dividend.
- opdata2  input  WIDTH  divisor.
- result  output  2*WIDTH  {remainder, quotient}.
- ready  output  1  result valid.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst high at an edge): state=IDLE, ready=0, result=0, counter=0. rst overrides all other inputs.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - start=1 and annul=0: latch the operands.
  - If opdata2==0, go to DIVZERO.
  - Otherwise go to ON with counter=0.
  - In signed mode, latch |opdata1| and |opdata2|, plus sign1=opdata1[WIDTH-1] and sign2=opdata2[WIDTH-1].
- DIVZERO: next edge goes to END with result=0 and ready=1.
- ON: each edge while counter<WIDTH performs one shift-subtract step and increments counter.
  - Step: shift {rem, dividend} left by 1.
  - If rem >= divisor, subtract the divisor and set quotient bit 1; otherwise set quotient bit 0.
- ON, edge with counter==WIDTH (finalise):
  - Signed mode: negate the quotient if sign1^sign2; negate the remainder if sign1.
  - Register result and set ready=1; go to END.
- END: hold result and ready=1 while start=1. On the first edge with start=0, go to IDLE with ready=0 and result=0.
- Latency, timed from the edge that samples start in IDLE:
  - Normal division: ready=1 after WIDTH+2 edges (34 for WIDTH=32).
  - Divide-by-zero: ready=1 after 2 edges.
- annul=1 in DIVZERO, ON or END: next edge goes to IDLE with ready=0, result=0, counter=0.
- annul=1 with start=1 in IDLE: stay in IDLE.
- start changes or new operands while busy: ignored. Operands are sampled only in IDLE.
- Back-to-back divisions: start held high through END and then dropped for one cycle. The earliest re-accept is the edge after returning to IDLE.
- Signed overflow (MIN / -1): quotient=MIN (wraps), remainder=0. No exception is flagged.
- Divide-by-zero result is 0 in both modes. The architecture leaves it UNPREDICTABLE, and the bench checks 0.
- busy is combinational from state. ready and result are registered.

Decomposition:
- Shared package (defines header): DIV_IDLE/DIV_ZERO/DIV_ON/DIV_END 2-bit state codes; DIV_READY/DIV_NOTREADY and DIV_START/DIV_STOP constants used by execute and control.
- One natural sub-module, div_step: a combinational single iteration.
  - Inputs: rem, dividend, divisor.
  - Outputs: next rem, next dividend/quotient shift, and the quotient bit.
  - Instantiated once inside div_unit.

Test Plan:
- Unsigned 100 / 7, WIDTH=32: ready after 34 edges; result={32'd2, 32'd14}; ready drops one edge after start falls.
- Signed -7 / 2 (0xFFFFFFF9, 0x2): result={32'hFFFFFFFF, 32'hFFFFFFFD}. Also 7 / -2 → {32'd1, 32'hFFFFFFFD}.
- Divide-by-zero 5 / 0, both modes: ready after 2 edges; result=0.
- Annul asserted at edge 10 of ON during 0xFFFFFFFF / 3: next edge ready=0, busy=0, result=0. A following unsigned 9 / 3 gives {0, 3} after 34 edges.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Also unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Reset asserted mid-ON and rst held with start=1: state stays IDLE, ready=0, result=0. Also rerun the directed cases with WIDTH=8 (e.g. 200 / 9 unsigned → {2, 22}, ready after 10 edges).

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state codes and the
// handshake constants used by execute and control.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_ZERO = 2'b01,
      DIV_ON   = 2'b10,
      DIV_END  = 2'b11
   } divState_t;

   localparam logic DIV_READY    = 1'b1;
   localparam logic DIV_NOTREADY = 1'b0;
   localparam logic DIV_START    = 1'b1;
   localparam logic DIV_STOP     = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration. The shifted dividend leaves its LSB
// clear; the caller ORs in qBit so the quotient grows into the freed bits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remNext,
   output logic [WIDTH-1:0] dividendNext,
   output logic             qBit
);

   // One extra bit: the shifted remainder can exceed WIDTH bits when the
   // divisor is above half range.
   logic [WIDTH:0] remWide;

   assign remWide      = {rem, dividend[WIDTH-1]};
   assign qBit         = (remWide >= {1'b0, divisor});
   assign remNext      = qBit ? (remWide[WIDTH-1:0] - divisor) : remWide[WIDTH-1:0];
   assign dividendNext = {dividend[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: result = {remainder, quotient},
// signed or unsigned, cancellable in flight via annul.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               annul,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               busy,
   output divState_t          dbgState
);

   // Handshake: the requester raises start with operands and holds it until
   // ready is seen; ready/result then hold until start drops, and the unit
   // returns to IDLE on that edge. Operands are sampled only in IDLE.

   divState_t        state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] divisor;
   logic             sign1;
   logic             sign2;

   logic [WIDTH-1:0] remNext;
   logic [WIDTH-1:0] dvdNext;
   logic             qBit;
   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH-1:0] quoFinal;
   logic [WIDTH-1:0] remFinal;

   div_step #(.WIDTH(WIDTH)) uStep (
      .rem          (rem),
      .dividend     (dvd),
      .divisor      (divisor),
      .remNext      (remNext),
      .dividendNext (dvdNext),
      .qBit         (qBit)
   );

   assign absA     = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
   assign absB     = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
   assign quoFinal = (sign1 ^ sign2) ? -dvd : dvd;
   assign remFinal = sign1 ? -rem : rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DIV_IDLE;
         ready   <= DIV_NOTREADY;
         result  <= '0;
         cnt     <= '0;
         rem     <= '0;
         dvd     <= '0;
         divisor <= '0;
         sign1   <= 1'b0;
         sign2   <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start == DIV_START && !annul) begin
                  dvd     <= absA;
                  divisor <= absB;
                  rem     <= '0;
                  cnt     <= '0;
                  sign1   <= signed_div & opdata1[WIDTH-1];
                  sign2   <= signed_div & opdata2[WIDTH-1];
                  state   <= (opdata2 == '0) ? DIV_ZERO : DIV_ON;
               end
            end
            DIV_ZERO: begin
               if (annul) begin
                  state <= DIV_IDLE;
                  ready <= DIV_NOTREADY;
                  cnt   <= '0;
               end else begin
                  state  <= DIV_END;
                  ready  <= DIV_READY;
               end
               result <= '0;
            end
            DIV_ON: begin
               if (annul) begin
                  state  <= DIV_IDLE;
                  ready  <= DIV_NOTREADY;
                  result <= '0;
                  cnt    <= '0;
               end else if (cnt != CNT_W'(WIDTH)) begin
                  rem <= remNext;
                  dvd <= dvdNext | WIDTH'(qBit);
                  cnt <= cnt + 1'b1;
               end else begin
                  // Sign fix-up: quotient follows sign1^sign2, remainder follows the dividend.
                  result <= {remFinal, quoFinal};
                  ready  <= DIV_READY;
                  state  <= DIV_END;
               end
            end
            DIV_END: begin
               if (annul || start == DIV_STOP) begin
                  state  <= DIV_IDLE;
                  ready  <= DIV_NOTREADY;
                  result <= '0;
                  cnt    <= '0;
               end
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

   assign busy     = (state != DIV_IDLE);
   assign dbgState = state;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed and randomised divisions at WIDTH=32 and WIDTH=8,
// checked against an arithmetic reference model through an expected queue.
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start = 1'b0, annul = 1'b0, signedDiv = 1'b0;
   logic [31:0] opA = '0, opB = '0;
   logic [63:0] result;
   logic        ready, busy;
   divState_t   state32;

   logic        start8 = 1'b0, annul8 = 1'b0, signedDiv8 = 1'b0;
   logic [7:0]  opA8 = '0, opB8 = '0;
   logic [15:0] result8;
   logic        ready8, busy8;
   divState_t   state8;

   int nCompared   = 0;
   int nMismatched = 0;
   logic [63:0] exp_q[$];

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .annul(annul), .signed_div(signedDiv),
      .opdata1(opA), .opdata2(opB), .result(result), .ready(ready), .busy(busy),
      .dbgState(state32)
   );

   div_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .annul(annul8), .signed_div(signedDiv8),
      .opdata1(opA8), .opdata2(opB8), .result(result8), .ready(ready8), .busy(busy8),
      .dbgState(state8)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: truncating signed/unsigned division on wide integers, packed {rem, quo}.
   function automatic logic [63:0] refDiv(input longint unsigned a, input longint unsigned b,
                                          input int w, input bit sgn);
      longint unsigned mask;
      longint          sa, sb, q, r;
      mask = (64'd1 << w) - 1;
      a = a & mask;
      b = b & mask;
      if (b == 0) return 64'd0;
      if (sgn) begin
         sa = ((a >> (w - 1)) & 1) != 0 ? longint'(a) - longint'(64'd1 << w) : longint'(a);
         sb = ((b >> (w - 1)) & 1) != 0 ? longint'(b) - longint'(64'd1 << w) : longint'(b);
         q  = sa / sb;
         r  = sa % sb;
      end else begin
         q = longint'(a / b);
         r = longint'(a % b);
      end
      return (($unsigned(r) & mask) << w) | ($unsigned(q) & mask);
   endfunction

   function automatic logic getReady(input int w);
      return (w == 32) ? ready : ready8;
   endfunction

   function automatic logic getBusy(input int w);
      return (w == 32) ? busy : busy8;
   endfunction

   function automatic logic [63:0] getResult(input int w);
      return (w == 32) ? result : {48'd0, result8};
   endfunction

   // driver tasks
   task automatic drive(input int w, input logic st, input logic [31:0] a,
                        input logic [31:0] b, input bit sgn);
      if (w == 32) begin
         start = st; opA = a; opB = b; signedDiv = sgn;
      end else begin
         start8 = st; opA8 = a[7:0]; opB8 = b[7:0]; signedDiv8 = sgn;
      end
   endtask

   task automatic set_start(input int w, input logic st);
      if (w == 32) start = st;
      else start8 = st;
   endtask

   task automatic step_edge();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: request, wait for ready, check latency and result,
   // hold one edge, drop start and check the return to idle.
   task automatic run_div(input int w, input logic [31:0] a, input logic [31:0] b,
                          input bit sgn, input bit scramble, input string tag);
      logic [63:0] expv, held;
      int          edges, expLat;
      bit          seen;
      exp_q.push_back(refDiv(a, b, w, sgn));
      expLat = ((w == 8 ? (b & 32'hFF) : b) == 0) ? 2 : w + 2;
      @(negedge clk);
      drive(w, 1'b1, a, b, sgn);
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 100) begin
         step_edge();
         edges++;
         if (getReady(w)) seen = 1'b1;
         else if (scramble) begin
            if (w == 32) begin opA = $urandom; opB = $urandom; signedDiv = $urandom_range(0, 1); end
            else begin opA8 = 8'($urandom); opB8 = 8'($urandom); signedDiv8 = 1'($urandom_range(0, 1)); end
         end
      end
      expv = exp_q.pop_front();
      nCompared++;
      if (!seen) begin
         nMismatched++;
         $display("FAIL %s timeout: no ready after %0d edges, required %0d", tag, edges, expLat);
         set_start(w, 1'b0);
         repeat (2) step_edge();
         return;
      end
      nCompared++;
      if (edges !== expLat) begin
         nMismatched++;
         $display("FAIL %s latency: got %0d edges, expected %0d", tag, edges, expLat);
      end
      nCompared++;
      if (getResult(w) !== expv) begin
         nMismatched++;
         $display("FAIL %s result: got %h, expected %h (a=%h b=%h signed=%0d)",
                  tag, getResult(w), expv, a, b, sgn);
      end
      held = getResult(w);
      step_edge();
      nCompared++;
      if (getReady(w) !== 1'b1 || getResult(w) !== held) begin
         nMismatched++;
         $display("FAIL %s hold: ready=%b result=%h, expected ready=1 result=%h",
                  tag, getReady(w), getResult(w), held);
      end
      set_start(w, 1'b0);
      step_edge();
      nCompared++;
      if (getReady(w) !== 1'b0 || getResult(w) !== 64'd0 || getBusy(w) !== 1'b0) begin
         nMismatched++;
         $display("FAIL %s release: ready=%b busy=%b result=%h, expected 0/0/0",
                  tag, getReady(w), getBusy(w), getResult(w));
      end
   endtask

   // scenarios
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step_edge();
      nCompared++;
      if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0 || state32 !== DIV_IDLE) begin
         nMismatched++;
         $display("FAIL reset32: ready=%b busy=%b result=%h, expected 0/0/0", ready, busy, result);
      end
      nCompared++;
      if (ready8 !== 1'b0 || busy8 !== 1'b0 || result8 !== 16'd0) begin
         nMismatched++;
         $display("FAIL reset8: ready=%b busy=%b result=%h, expected 0/0/0", ready8, busy8, result8);
      end
      rst = 1'b0;
      step_edge();
   endtask

   task automatic test_unsigned();
      run_div(32, 32'd100, 32'd7, 1'b0, 1'b0, "u100_7");
      run_div(32, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, "umax_1");
      run_div(32, 32'h80000001, 32'hFFFFFFFE, 1'b0, 1'b0, "u_bigdivisor");
   endtask

   task automatic test_signed();
      run_div(32, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, "s-7_2");
      run_div(32, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, "s7_-2");
      run_div(32, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 1'b0, "s-7_-2");
   endtask

   task automatic test_divzero();
      run_div(32, 32'd5, 32'd0, 1'b0, 1'b0, "zero_u");
      run_div(32, 32'd5, 32'd0, 1'b1, 1'b0, "zero_s");
   endtask

   task automatic test_overflow();
      run_div(32, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, "s_min_-1");
   endtask

   task automatic test_annul();
      @(negedge clk);
      drive(32, 1'b1, 32'hFFFFFFFF, 32'd3, 1'b0);
      repeat (11) step_edge();
      annul = 1'b1;
      step_edge();
      nCompared++;
      if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
         nMismatched++;
         $display("FAIL annul_on: ready=%b busy=%b result=%h, expected 0/0/0", ready, busy, result);
      end
      // start with annul in IDLE must not launch anything
      repeat (2) step_edge();
      nCompared++;
      if (busy !== 1'b0) begin
         nMismatched++;
         $display("FAIL annul_idle: busy=%b, expected 0", busy);
      end
      annul = 1'b0;
      start = 1'b0;
      step_edge();
      run_div(32, 32'd9, 32'd3, 1'b0, 1'b0, "after_annul");
      // annul while in DIVZERO
      @(negedge clk);
      drive(32, 1'b1, 32'd5, 32'd0, 1'b0);
      step_edge();
      annul = 1'b1;
      step_edge();
      nCompared++;
      if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
         nMismatched++;
         $display("FAIL annul_zero: ready=%b busy=%b result=%h, expected 0/0/0", ready, busy, result);
      end
      annul = 1'b0;
      start = 1'b0;
      step_edge();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive(32, 1'b1, 32'd1000, 32'd3, 1'b0);
      repeat (6) step_edge();
      rst = 1'b1;
      step_edge();
      nCompared++;
      if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
         nMismatched++;
         $display("FAIL reset_mid: ready=%b busy=%b result=%h, expected 0/0/0", ready, busy, result);
      end
      repeat (3) step_edge();
      nCompared++;
      if (busy !== 1'b0 || state32 !== DIV_IDLE || ready !== 1'b0) begin
         nMismatched++;
         $display("FAIL reset_hold: busy=%b ready=%b, expected 0/0 with start held", busy, ready);
      end
      rst = 1'b0;
      start = 1'b0;
      step_edge();
   endtask

   task automatic test_back_to_back();
      run_div(32, 32'd1234567, 32'd89, 1'b0, 1'b0, "b2b_1");
      run_div(32, 32'hFFFF0000, 32'd77, 1'b1, 1'b1, "b2b_2_scramble");
      run_div(32, 32'd42, 32'd43, 1'b0, 1'b0, "b2b_3");
   endtask

   task automatic test_width8();
      run_div(8, 32'd200, 32'd9, 1'b0, 1'b0, "w8_200_9");
      run_div(8, 32'hF9, 32'h02, 1'b1, 1'b0, "w8_s-7_2");
      run_div(8, 32'h80, 32'hFF, 1'b1, 1'b0, "w8_min_-1");
      run_div(8, 32'd5, 32'd0, 1'b1, 1'b0, "w8_zero");
      run_div(8, 32'hFF, 32'd1, 1'b0, 1'b0, "w8_max_1");
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      int          w;
      for (int i = 0; i < 30; i++) begin
         w = ($urandom_range(0, 2) == 0) ? 8 : 32;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 28);
         run_div(w, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_divzero();
      test_overflow();
      test_annul();
      test_reset_mid();
      test_back_to_back();
      test_width8();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
